// File: rtl/seq_divider_module_if.sv
// ---------------------------------------------------------------------------
// seq_divider_module_if
//
// Purpose: bundles the start/done handshake and the operand/result bus of the
// sequential restoring divider so that the controller and the divider share
// one connection object.
//
// Signals:
//   start        controller -> divider  request a division (seen only in IDLE)
//   dividend     controller -> divider  unsigned dividend, width bits
//   divisor      controller -> divider  unsigned divisor, width bits
//   busy         divider -> controller  high while the divider is iterating
//   done         divider -> controller  one-cycle pulse, results valid
//   quotient     divider -> controller  unsigned quotient, width bits
//   remainder    divider -> controller  unsigned remainder, width bits
//   div_by_zero  divider -> controller  captured divisor was zero
//
// Modports:
//   master  the controller side (drives start and operands)
//   slave   the divider side (drives status and results)
// ---------------------------------------------------------------------------
interface seq_divider_module_if #(
   parameter int width = 4
) ();

   logic             start;
   logic [width-1:0] dividend;
   logic [width-1:0] divisor;
   logic             busy;
   logic             done;
   logic [width-1:0] quotient;
   logic [width-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_divider_module.sv
// ---------------------------------------------------------------------------
// seq_divider_module
//
// Purpose: sequential restoring unsigned divider producing one quotient bit
// per clock. Each iteration shifts {R,Q} left, trial-subtracts the divisor
// from the partial remainder and keeps or restores the result depending on
// its sign. A zero divisor short-circuits straight to the result cycle.
//
// Parameters:
//   width   operand / quotient / remainder width in bits (2 to 16)
//
// Ports:
//   clk     rising-edge clock for all state
//   rst     synchronous, active-high reset
//   bus     seq_divider_module_if slave modport:
//             start, dividend, divisor           (inputs)
//             busy, done, quotient, remainder,
//             div_by_zero                        (registered outputs)
// ---------------------------------------------------------------------------
module seq_divider_module #(
   parameter int width = 4
) (
   input logic                  clk,
   input logic                  rst,
   seq_divider_module_if.slave  bus
);

   localparam int CountWidth = $clog2(width + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t                state_q;
   logic [CountWidth-1:0] count_q;
   logic [width-1:0]      qReg_q;
   logic [width-1:0]      divisor_q;
   logic [width-1:0]      partRem_q;
   logic                  busy_q;
   logic                  done_q;
   logic [width-1:0]      quotient_q;
   logic [width-1:0]      remainder_q;
   logic                  divZero_q;

   logic [width:0]        remShift;
   logic [width:0]        trial;
   logic [width-1:0]      partRem_d;
   logic [width-1:0]      qReg_d;

   // One restoring step. The partial remainder is always below the divisor,
   // so only width bits are stored; the shifted value needs width+1 bits.
   // When the trial difference is negative the shifted remainder is still
   // below the divisor, so its top bit is zero and dropping it loses nothing.
   // When the difference is non-negative it is below the divisor as well.
   always_comb begin
      remShift  = {partRem_q, qReg_q[width-1]};
      trial     = remShift - {1'b0, divisor_q};
      partRem_d = remShift[width-1:0];
      qReg_d    = {qReg_q[width-2:0], 1'b0};
      if (!trial[width]) begin
         partRem_d = trial[width-1:0];
         qReg_d    = {qReg_q[width-2:0], 1'b1};
      end
   end

   // Control FSM and all registered state. Outputs are registered here so
   // busy and done come straight from flops. The quotient and remainder
   // outputs are loaded from the final iteration's next values on the same
   // edge that enters DONE, which makes them valid in the done cycle. They
   // keep their value otherwise, so the controller can read them later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         qReg_q      <= '0;
         divisor_q   <= '0;
         partRem_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         divZero_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  qReg_q    <= bus.dividend;
                  divisor_q <= bus.divisor;
                  partRem_q <= '0;
                  divZero_q <= 1'b0;
                  if (bus.divisor != '0) begin
                     count_q <= CountWidth'(width);
                     busy_q  <= 1'b1;
                     state_q <= CALC;
                  end else begin
                     divZero_q   <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= bus.dividend;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end

            CALC: begin
               partRem_q <= partRem_d;
               qReg_q    <= qReg_d;
               count_q   <= count_q - CountWidth'(1);
               if (count_q == CountWidth'(1)) begin
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  quotient_q  <= qReg_d;
                  remainder_q <= partRem_d;
                  state_q     <= DONE;
               end
            end

            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = divZero_q;

endmodule
